// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_pkg
// Description : Shared definitions for the I2C bit engine.
//               - slot-select encodings driven by the master control FSM
//               - engine state enumeration
//               - default SCL quarter-period divider
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

    // Slot select encodings on 'sel'
    localparam logic [1:0] SEL_START = 2'b00;
    localparam logic [1:0] SEL_ADDR  = 2'b01;
    localparam logic [1:0] SEL_DATA  = 2'b10;
    localparam logic [1:0] SEL_IDLE  = 2'b11;

    // Default number of system clocks per SCL quarter period
    localparam int QDIV_DEFAULT = 4;

    // Bit-engine states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_SHIFT = 3'd2,
        ST_ACK   = 3'd3,
        ST_STOP  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/i2c_bit_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : i2c_bit_engine_if
// Description : Bundle between the master control FSM, the bit engine and the
//               open-drain pad logic.
//   Control (master -> engine): en, sel[1:0], newcount, addr[6:0], rw,
//                               data[7:0], stop
//   Pad     (pad -> engine)   : iSDA
//   Status  (engine -> others): scl, oSDA, sda_oe, bit8, ack, ack_valid, busy
// Modports    : master (control FSM), slave (bit engine), pad (pad logic)
// Revision    : 1.0 - initial release
// ============================================================================
interface i2c_bit_engine_if;
    logic       en;
    logic [1:0] sel;
    logic       newcount;
    logic [6:0] addr;
    logic       rw;
    logic [7:0] data;
    logic       stop;
    logic       iSDA;
    logic       scl;
    logic       oSDA;
    logic       sda_oe;
    logic       bit8;
    logic       ack;
    logic       ack_valid;
    logic       busy;

    modport master (
        output en, sel, newcount, addr, rw, data, stop,
        input  scl, oSDA, sda_oe, bit8, ack, ack_valid, busy
    );

    modport slave (
        input  en, sel, newcount, addr, rw, data, stop, iSDA,
        output scl, oSDA, sda_oe, bit8, ack, ack_valid, busy
    );

    modport pad (
        output iSDA,
        input  scl, oSDA, sda_oe
    );
endinterface
`default_nettype wire

// File: rtl/i2c_qtick_gen.sv
`default_nettype none
// ============================================================================
// Module      : i2c_qtick_gen
// Description : SCL quarter-period divider and phase counter.
//   clk, rst  : system clock, asynchronous active-high reset
//   i_run     : count while high; both counters are held at 0 while low
//   o_qtick   : one-clock pulse on the last clock of each quarter
//   o_ph[1:0] : current quarter (0,1 = SCL low, 2,3 = SCL high)
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_qtick_gen #(
    parameter int QDIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_run,
    output logic       o_qtick,
    output logic [1:0] o_ph
);

    localparam int           c_QW    = $clog2(QDIV);
    localparam logic [c_QW-1:0] c_QLAST = c_QW'(QDIV - 1);

    logic [c_QW-1:0] r_qcnt;
    logic [1:0]      r_ph;

    assign o_qtick = i_run && (r_qcnt == c_QLAST);
    assign o_ph    = r_ph;

    // Idle clears both counters so every slot starts at quarter 0, clock 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_qcnt <= '0;
            r_ph   <= 2'd0;
        end else if (!i_run) begin
            r_qcnt <= '0;
            r_ph   <= 2'd0;
        end else if (o_qtick) begin
            r_qcnt <= '0;
            r_ph   <= r_ph + 2'd1;
        end else begin
            r_qcnt <= r_qcnt + c_QW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2c_bit_engine.sv
`default_nettype none
// ============================================================================
// Module      : i2c_bit_engine
// Description : Bit-level I2C serializer. Generates SCL, drives/releases SDA
//               for START, address/data bytes, ACK and STOP slots and samples
//               the slave ACK.
//   clk, rst  : system clock, asynchronous active-high reset
//   bus       : i2c_bit_engine_if.slave (control in, SCL/SDA/status out)
//   QDIV      : system clocks per SCL quarter period (>= 2)
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_bit_engine
    import i2c_pkg::*;
#(
    parameter int QDIV = QDIV_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    i2c_bit_engine_if.slave bus
);

    state_t     r_state;
    logic       r_scl;
    logic       r_sda;
    logic       r_oe;
    logic       r_bit8;
    logic       r_ack;
    logic       r_ack_valid;
    logic [6:0] r_shreg;    // bits still to send after the one on r_sda
    logic [2:0] r_bitcnt;

    logic       w_run;
    logic       w_qtick;
    logic [1:0] w_ph;
    logic [7:0] w_load;

    assign w_run  = (r_state != ST_IDLE);
    assign w_load = (bus.sel == SEL_ADDR) ? {bus.addr, bus.rw} : bus.data;

    i2c_qtick_gen #(
        .QDIV (QDIV)
    ) u_qtick (
        .clk     (clk),
        .rst     (rst),
        .i_run   (w_run),
        .o_qtick (w_qtick),
        .o_ph    (w_ph)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_scl       <= 1'b1;
            r_sda       <= 1'b1;
            r_oe        <= 1'b0;
            r_bit8      <= 1'b0;
            r_ack       <= 1'b0;
            r_ack_valid <= 1'b0;
            r_shreg     <= 7'd0;
            r_bitcnt    <= 3'd0;
        end else begin
            r_bit8      <= 1'b0;
            r_ack_valid <= 1'b0;
            if (!bus.en) begin
                // Disabled: park the bus released, whatever was in flight.
                r_state <= ST_IDLE;
                r_scl   <= 1'b1;
                r_sda   <= 1'b1;
                r_oe    <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        // stop outranks any same-cycle newcount
                        if (bus.stop) begin
                            r_state <= ST_STOP;
                            r_scl   <= 1'b0;
                            r_sda   <= 1'b0;
                            r_oe    <= 1'b1;
                        end else if (bus.sel == SEL_START) begin
                            r_state <= ST_START;
                            r_scl   <= 1'b1;
                            r_sda   <= 1'b1;
                            r_oe    <= 1'b1;
                        end else if (bus.newcount &&
                                     (bus.sel == SEL_ADDR || bus.sel == SEL_DATA)) begin
                            r_state  <= ST_SHIFT;
                            r_shreg  <= w_load[6:0];
                            r_bitcnt <= 3'd0;
                            r_scl    <= 1'b0;
                            r_sda    <= w_load[7];
                            r_oe     <= 1'b1;
                        end
                    end

                    ST_START: begin
                        if (w_qtick) begin
                            if (w_ph == 2'd1) r_sda <= 1'b0;
                            // Leave with SCL high and SDA held low.
                            if (w_ph == 2'd3) r_state <= ST_IDLE;
                        end
                    end

                    ST_SHIFT: begin
                        if (w_qtick) begin
                            if (w_ph == 2'd1) r_scl <= 1'b1;
                            if (w_ph == 2'd3) begin
                                r_scl <= 1'b0;
                                if (r_bitcnt == 3'd7) begin
                                    r_bit8  <= 1'b1;
                                    r_state <= ST_ACK;
                                    r_sda   <= 1'b1;
                                    r_oe    <= 1'b0;
                                end else begin
                                    r_sda    <= r_shreg[6];
                                    r_shreg  <= {r_shreg[5:0], 1'b0};
                                    r_bitcnt <= r_bitcnt + 3'd1;
                                end
                            end
                        end
                    end

                    ST_ACK: begin
                        if (w_qtick) begin
                            if (w_ph == 2'd1) r_scl <= 1'b1;
                            if (w_ph == 2'd2) begin
                                r_ack       <= ~bus.iSDA;
                                r_ack_valid <= 1'b1;
                            end
                            if (w_ph == 2'd3) begin
                                r_scl   <= 1'b0;
                                r_state <= ST_IDLE;
                            end
                        end
                    end

                    ST_STOP: begin
                        if (w_qtick) begin
                            if (w_ph == 2'd0) r_scl <= 1'b1;
                            if (w_ph == 2'd1) r_sda <= 1'b1;
                            if (w_ph == 2'd3) begin
                                r_oe    <= 1'b0;
                                r_state <= ST_IDLE;
                            end
                        end
                    end

                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.scl       = r_scl;
    assign bus.oSDA      = r_sda;
    assign bus.sda_oe    = r_oe;
    assign bus.bit8      = r_bit8;
    assign bus.ack       = r_ack;
    assign bus.ack_valid = r_ack_valid;
    assign bus.busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_i2c_bit_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_bit_engine
// Description : Self-checking bench for i2c_bit_engine. A waveform-level model
//               derives every output from the slot type and the number of
//               clocks elapsed since the slot began; directed checks pin the
//               model with hand-computed values, then random slots follow.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_bit_engine;
    import i2c_pkg::*;

    localparam int Q      = 4;
    localparam int M_IDLE = 0;
    localparam int M_START = 1;
    localparam int M_SHIFT = 2;
    localparam int M_STOP  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    i2c_bit_engine_if bus ();

    i2c_bit_engine #(.QDIV(Q)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int nc_cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural model ----------------
    int         m_mode = M_IDLE;
    int         m_t    = 0;
    int         tt, bi;
    logic [7:0] m_byte = 8'd0;
    logic e_scl = 1'b1, e_sda = 1'b1, e_oe = 1'b0, e_bit8 = 1'b0, e_ack = 1'b0, e_av = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = M_IDLE; m_t = 0;
            e_scl = 1'b1; e_sda = 1'b1; e_oe = 1'b0;
            e_bit8 = 1'b0; e_ack = 1'b0; e_av = 1'b0;
        end else begin
            e_bit8 = 1'b0;
            e_av   = 1'b0;
            if (!bus.en) begin
                m_mode = M_IDLE;
                e_scl = 1'b1; e_sda = 1'b1; e_oe = 1'b0;
            end else begin
                if (m_mode == M_IDLE) begin
                    m_t = 0;
                    if (bus.stop) m_mode = M_STOP;
                    else if (bus.sel == SEL_START) m_mode = M_START;
                    else if (bus.newcount && bus.sel != SEL_IDLE) begin
                        m_mode = M_SHIFT;
                        m_byte = (bus.sel == SEL_ADDR) ? {bus.addr, bus.rw} : bus.data;
                    end
                end else begin
                    m_t++;
                end
                case (m_mode)
                    M_START: begin
                        if (m_t == 4*Q) begin
                            m_mode = M_IDLE; e_scl = 1'b1; e_sda = 1'b0; e_oe = 1'b1;
                        end else begin
                            e_scl = 1'b1; e_oe = 1'b1; e_sda = (m_t < 2*Q);
                        end
                    end
                    M_STOP: begin
                        if (m_t == 4*Q) begin
                            m_mode = M_IDLE; e_scl = 1'b1; e_sda = 1'b1; e_oe = 1'b0;
                        end else begin
                            e_scl = (m_t >= Q); e_sda = (m_t >= 2*Q); e_oe = 1'b1;
                        end
                    end
                    M_SHIFT: begin
                        if (m_t < 32*Q) begin
                            bi    = 7 - m_t / (4*Q);
                            e_scl = ((m_t % (4*Q)) >= 2*Q);
                            e_sda = m_byte[bi[2:0]];
                            e_oe  = 1'b1;
                        end else if (m_t < 36*Q) begin
                            tt     = m_t - 32*Q;
                            e_bit8 = (tt == 0);
                            e_scl  = (tt >= 2*Q);
                            e_sda  = 1'b1;
                            e_oe   = 1'b0;
                            if (tt == 3*Q) begin
                                e_ack = ~bus.iSDA;
                                e_av  = 1'b1;
                            end
                        end else begin
                            m_mode = M_IDLE; e_scl = 1'b0; e_sda = 1'b1; e_oe = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    task automatic check1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkn(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        check1("scl",       bus.scl,       e_scl);
        check1("oSDA",      bus.oSDA,      e_sda);
        check1("sda_oe",    bus.sda_oe,    e_oe);
        check1("bit8",      bus.bit8,      e_bit8);
        check1("ack",       bus.ack,       e_ack);
        check1("ack_valid", bus.ack_valid, e_av);
        check1("busy",      bus.busy,      m_mode != M_IDLE);
    end

    // ---------------- bus-level monitors ----------------
    logic       line, p_line = 1'b1, p_scl = 1'b1;
    logic [7:0] cap = 8'd0;
    int         ncap = 0, n_start = 0, n_stop = 0, n_bit8 = 0, n_av = 0, last_b8 = 0;

    always @(negedge clk) begin
        line = !(bus.sda_oe && !bus.oSDA);
        if (!p_scl && bus.scl && bus.sda_oe) begin
            cap  = {cap[6:0], line};
            ncap = ncap + 1;
        end
        if (p_scl && bus.scl && p_line && !line) n_start = n_start + 1;
        if (p_scl && bus.scl && !p_line && line) n_stop = n_stop + 1;
        if (bus.bit8) begin
            n_bit8  = n_bit8 + 1;
            last_b8 = cyc;
        end
        if (bus.ack_valid) n_av = n_av + 1;
        p_line = line;
        p_scl  = bus.scl;
    end

    always @(posedge clk) begin
        if (!rst) assert (!(bus.newcount && bus.busy))
            else $error("newcount issued while engine busy");
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [1:0] s, input logic nc, input logic st,
                         input logic [6:0] a, input logic r, input logic [7:0] d);
        @(negedge clk);
        bus.sel = s; bus.newcount = nc; bus.stop = st;
        bus.addr = a; bus.rw = r; bus.data = d;
        @(negedge clk);
        nc_cyc = cyc;
        bus.sel = SEL_IDLE; bus.newcount = 1'b0; bus.stop = 1'b0;
    endtask

    task automatic wait_idle(input logic rnd);
        int n = 0;
        while (m_mode != M_IDLE && n < 1000) begin
            @(negedge clk);
            if (rnd) bus.iSDA = 1'($urandom);
            n++;
        end
        if (n >= 1000) begin
            miscompares++;
            $display("FAIL wait_idle: timeout, got busy, expected idle");
        end
        repeat (2) @(negedge clk);
    endtask

    int s0, s1, s2, op;

    initial begin
        bus.en = 1'b1; bus.sel = SEL_IDLE; bus.newcount = 1'b0; bus.stop = 1'b0;
        bus.addr = 7'd0; bus.rw = 1'b0; bus.data = 8'd0; bus.iSDA = 1'b1;
        repeat (3) @(negedge clk);
        check1("rst_scl",    bus.scl,    1'b1);
        check1("rst_oSDA",   bus.oSDA,   1'b1);
        check1("rst_sda_oe", bus.sda_oe, 1'b0);
        check1("rst_busy",   bus.busy,   1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Address 0x50, write; slave ACKs
        s0 = ncap; s1 = n_bit8; s2 = n_av;
        bus.iSDA = 1'b0;
        drive(SEL_ADDR, 1'b1, 1'b0, 7'h50, 1'b0, 8'h00);
        wait_idle(1'b0);
        checkn("addr_nbits",   ncap - s0, 8);
        checkn("addr_bits",    int'(cap), 8'hA0);
        checkn("addr_bit8s",   n_bit8 - s1, 1);
        checkn("bit8_latency", last_b8 - nc_cyc, 128);
        checkn("ack_pulses",   n_av - s2, 1);
        check1("ack_when_low", bus.ack, 1'b1);

        // Data 0x3C; slave NACKs
        s0 = ncap;
        bus.iSDA = 1'b1;
        drive(SEL_DATA, 1'b1, 1'b0, 7'h00, 1'b0, 8'h3C);
        wait_idle(1'b0);
        checkn("data_bits",     int'(cap), 8'h3C);
        check1("ack_when_high", bus.ack, 1'b0);

        // START then STOP
        s0 = n_start; s1 = n_stop;
        drive(SEL_START, 1'b0, 1'b0, 7'h00, 1'b0, 8'h00);
        wait_idle(1'b0);
        checkn("start_cond", n_start - s0, 1);
        drive(SEL_IDLE, 1'b0, 1'b1, 7'h00, 1'b0, 8'h00);
        wait_idle(1'b0);
        checkn("stop_cond",   n_stop - s1, 1);
        check1("stop_scl",    bus.scl, 1'b1);
        check1("stop_sda_oe", bus.sda_oe, 1'b0);

        // Abort after the 3rd bit of 0xA5
        s1 = n_bit8;
        drive(SEL_DATA, 1'b1, 1'b0, 7'h00, 1'b0, 8'hA5);
        repeat (12*Q + 2) @(negedge clk);
        bus.en = 1'b0;
        @(negedge clk);
        check1("abort_scl",    bus.scl, 1'b1);
        check1("abort_sda_oe", bus.sda_oe, 1'b0);
        check1("abort_busy",   bus.busy, 1'b0);
        bus.en = 1'b1;
        repeat (160) @(negedge clk);
        checkn("abort_no_bit8", n_bit8 - s1, 0);

        // stop and newcount in the same clock
        s0 = n_stop; s1 = n_bit8;
        drive(SEL_DATA, 1'b1, 1'b1, 7'h00, 1'b0, 8'h00);
        wait_idle(1'b0);
        repeat (160) @(negedge clk);
        checkn("collide_stop",    n_stop - s0, 1);
        checkn("collide_no_bit8", n_bit8 - s1, 0);

        // Asynchronous reset mid-byte while SCL is low
        drive(SEL_ADDR, 1'b1, 1'b0, 7'h2B, 1'b1, 8'h00);
        repeat (36) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check1("arst_scl",    bus.scl, 1'b1);
        check1("arst_sda_oe", bus.sda_oe, 1'b0);
        check1("arst_bit8",   bus.bit8, 1'b0);
        check1("arst_busy",   bus.busy, 1'b0);
        check1("arst_ack",    bus.ack, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Random slot sequence
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 7);
            case (op)
                0: drive(SEL_START, 1'b0, 1'b0, 7'h00, 1'b0, 8'h00);
                1: drive(SEL_ADDR, 1'b1, 1'b0, 7'($urandom), 1'($urandom), 8'h00);
                2: drive(SEL_DATA, 1'b1, 1'b0, 7'h00, 1'b0, 8'($urandom));
                3: drive(SEL_IDLE, 1'b0, 1'b1, 7'h00, 1'b0, 8'h00);
                4: drive(SEL_IDLE, 1'b1, 1'b0, 7'($urandom), 1'b0, 8'($urandom));
                5: repeat ($urandom_range(1, 10)) @(negedge clk);
                6: begin
                    drive(SEL_DATA, 1'b1, 1'b0, 7'h00, 1'b0, 8'($urandom));
                    repeat ($urandom_range(1, 140)) begin
                        @(negedge clk);
                        bus.iSDA = 1'($urandom);
                    end
                    bus.en = 1'b0;
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                    bus.en = 1'b1;
                end
                default: drive(SEL_ADDR, 1'b1, 1'b1, 7'($urandom), 1'b0, 8'h00);
            endcase
            wait_idle(1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
